// File: rtl/display_capture.sv
// Receive side of the multiplexed two-digit display bus: reassembles hi/lo digit
// pairs into an 8-bit value, filters it for stability and reports updates/errors.
module display_capture #(
  parameter int BASE   = 16,
  parameter int STABLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       cat,
  output logic [7:0] num,
  output logic       valid,
  output logic       upd,
  output logic       err
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  localparam logic [4:0] BASE_W5  = 5'(BASE);
  localparam logic [7:0] BASE_W8  = 8'(BASE);
  localparam logic [3:0] STABLE_W = 4'(STABLE);

  state_t     state_r, state_s;
  logic [3:0] held_digit_r, held_digit_s;
  logic       held_cat_r, held_cat_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] cand_r, cand_s;
  logic [7:0] num_s;
  logic       valid_s, upd_s, err_s;

  logic       range_err_s;
  logic       pair_s;
  logic [3:0] hi_s, lo_s;
  logic [7:0] pair_val_s;

  assign range_err_s = ({1'b0, bcd} >= BASE_W5);
  assign pair_s      = (state_r == HELD) && (cat != held_cat_r);
  // The digit with cat=1 is always the high digit, whichever arrived first.
  assign hi_s        = cat ? bcd : held_digit_r;
  assign lo_s        = cat ? held_digit_r : bcd;
  assign pair_val_s  = ({4'h0, hi_s} * BASE_W8) + {4'h0, lo_s};

  // Hold FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Hold FSM next-state logic: an illegal digit always drops back to EMPTY
  always_comb begin
    state_s = state_r;
    if (range_err_s) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY:   state_s = HELD;
        HELD:    state_s = HELD;
        default: state_s = EMPTY;
      endcase
    end
  end

  // Datapath next values: digit hold, stability filter and strobes
  always_comb begin
    held_digit_s = held_digit_r;
    held_cat_s   = held_cat_r;
    cnt_s        = cnt_r;
    cand_s       = cand_r;
    num_s        = num;
    valid_s      = valid;
    upd_s        = 1'b0;
    err_s        = 1'b0;
    if (range_err_s) begin
      err_s = 1'b1;
      cnt_s = 4'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          held_digit_s = bcd;
          held_cat_s   = cat;
        end
        HELD: begin
          held_digit_s = bcd;
          held_cat_s   = cat;
          if (pair_s) begin
            if (pair_val_s == cand_r) begin
              cnt_s = (cnt_r == STABLE_W) ? cnt_r : cnt_r + 4'd1;
            end else begin
              cand_s = pair_val_s;
              cnt_s  = 4'd1;
            end
            if ((cnt_s == STABLE_W) && ((cand_s != num) || !valid)) begin
              num_s   = cand_s;
              valid_s = 1'b1;
              upd_s   = 1'b1;
            end else begin
              upd_s   = 1'b0;
            end
          end else begin
            // Same digit repeated: the run of matching pairs is broken.
            cnt_s = 4'd0;
          end
        end
        default: begin
          cnt_s = 4'd0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      held_digit_r <= 4'd0;
      held_cat_r   <= 1'b0;
      cnt_r        <= 4'd0;
      cand_r       <= 8'd0;
      num          <= 8'd0;
      valid        <= 1'b0;
      upd          <= 1'b0;
      err          <= 1'b0;
    end else begin
      held_digit_r <= held_digit_s;
      held_cat_r   <= held_cat_s;
      cnt_r        <= cnt_s;
      cand_r       <= cand_s;
      num          <= num_s;
      valid        <= valid_s;
      upd          <= upd_s;
      err          <= err_s;
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: three configurations share one bus; a directed
// vector table plus randomized traffic, all checked against a queue-based model.
module tb_display_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cat = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic [7:0] d_num   [3];
  logic       d_valid [3];
  logic       d_upd   [3];
  logic       d_err   [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  display_capture #(.BASE(16), .STABLE(1)) u0 (.clk(clk), .rst(rst), .bcd(bcd), .cat(cat),
    .num(d_num[0]), .valid(d_valid[0]), .upd(d_upd[0]), .err(d_err[0]));
  display_capture #(.BASE(10), .STABLE(2)) u1 (.clk(clk), .rst(rst), .bcd(bcd), .cat(cat),
    .num(d_num[1]), .valid(d_valid[1]), .upd(d_upd[1]), .err(d_err[1]));
  display_capture #(.BASE(16), .STABLE(2)) u2 (.clk(clk), .rst(rst), .bcd(bcd), .cat(cat),
    .num(d_num[2]), .valid(d_valid[2]), .upd(d_upd[2]), .err(d_err[2]));

  // Reference model: a pending digit plus the list of pair values since the last break.
  int bases   [3] = '{16, 10, 16};
  int stables [3] = '{1, 2, 2};
  int m_num   [3];
  bit m_valid [3];
  bit m_upd   [3];
  bit m_err   [3];
  bit pv      [3];
  int pd      [3];
  int pc      [3];
  int hist    [3][$];

  task automatic model_step(input int i, input bit r, input bit c, input int b);
    int hi, lo, v, n;
    bit ok;
    m_upd[i] = 1'b0;
    m_err[i] = 1'b0;
    if (r) begin
      m_num[i] = 0; m_valid[i] = 1'b0; pv[i] = 1'b0; hist[i].delete();
    end else if (b >= bases[i]) begin
      m_err[i] = 1'b1; pv[i] = 1'b0; hist[i].delete();
    end else if (!pv[i]) begin
      pv[i] = 1'b1; pd[i] = b; pc[i] = c;
    end else if (pc[i] == int'(c)) begin
      pd[i] = b; hist[i].delete();
    end else begin
      hi = c ? b : pd[i];
      lo = c ? pd[i] : b;
      v = hi * bases[i] + lo;
      hist[i].push_back(v);
      if (hist[i].size() > 20) void'(hist[i].pop_front());
      pd[i] = b; pc[i] = c;
      n = hist[i].size();
      ok = (n >= stables[i]);
      if (ok) for (int k = 0; k < stables[i]; k++) if (hist[i][n-1-k] != v) ok = 1'b0;
      if (ok && (v != m_num[i] || !m_valid[i])) begin
        m_num[i] = v; m_valid[i] = 1'b1; m_upd[i] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one sample, clock it, then compare every instance with the model.
  task automatic apply(input bit r, input bit c, input logic [3:0] b);
    rst = r; cat = c; bcd = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i, r, c, int'(b));
      check($sformatf("model num[%0d]", i), int'(d_num[i]), m_num[i]);
      check($sformatf("model valid[%0d]", i), int'(d_valid[i]), int'(m_valid[i]));
      check($sformatf("model upd[%0d]", i), int'(d_upd[i]), int'(m_upd[i]));
      check($sformatf("model err[%0d]", i), int'(d_err[i]), int'(m_err[i]));
      check($sformatf("upd&err[%0d]", i), int'(d_upd[i] & d_err[i]), 0);
    end
  endtask

  typedef struct {
    bit         r;
    bit         c;
    logic [3:0] b;
    int         idx;
    logic [7:0] num;
    bit         valid;
    bit         upd;
    bit         err;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, logic [3:0] b, int idx,
                              logic [7:0] n, bit v, bit u, bit e);
    vec_t x;
    x.r = r; x.c = c; x.b = b; x.idx = idx; x.num = n; x.valid = v; x.upd = u; x.err = e;
    return x;
  endfunction

  vec_t vt[$];
  int   pat_lo, pat_hi, phase;
  bit   rc, rr;
  logic [3:0] rb;

  initial begin
    // Instance 0: BASE16/STABLE1 basic pair, repeat-cat, reset mid-pair
    vt.push_back(mk(1'b1, 1'b0, 4'h0, 0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hD, 0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h2, 0, 8'h2D, 1'b1, 1'b1, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hD, 0, 8'h2D, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h2, 0, 8'h2D, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h3, 0, 8'h2D, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h6, 0, 8'h2D, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'h1, 0, 8'h61, 1'b1, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 4'h0, 0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'h5, 0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 4'h0, 0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h7, 0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'h8, 0, 8'h78, 1'b1, 1'b1, 1'b0));
    // Instance 1: BASE10/STABLE2 acceptance and range error
    vt.push_back(mk(1'b1, 1'b0, 4'h0, 1, 8'd0,  1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'h7, 1, 8'd0,  1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h4, 1, 8'd0,  1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'h7, 1, 8'd47, 1'b1, 1'b1, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h4, 1, 8'd47, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hA, 1, 8'd47, 1'b1, 1'b0, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 4'h4, 1, 8'd47, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'h7, 1, 8'd47, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h4, 1, 8'd47, 1'b1, 1'b0, 1'b0));
    // Instance 2: BASE16/STABLE2 glitch rejection
    vt.push_back(mk(1'b1, 1'b0, 4'h0, 2, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hA, 2, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h5, 2, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hA, 2, 8'h5A, 1'b1, 1'b1, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h5, 2, 8'h5A, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'hF, 2, 8'h5A, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hA, 2, 8'h5A, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 4'h5, 2, 8'h5A, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'hA, 2, 8'h5A, 1'b1, 1'b0, 1'b0));

    for (int i = 0; i < 3; i++) begin
      m_num[i] = 0; m_valid[i] = 1'b0; pv[i] = 1'b0; pd[i] = 0; pc[i] = 0;
    end
    @(negedge clk);

    foreach (vt[k]) begin
      apply(vt[k].r, vt[k].c, vt[k].b);
      check($sformatf("vec%0d num", k),   int'(d_num[vt[k].idx]),   int'(vt[k].num));
      check($sformatf("vec%0d valid", k), int'(d_valid[vt[k].idx]), int'(vt[k].valid));
      check($sformatf("vec%0d upd", k),   int'(d_upd[vt[k].idx]),   int'(vt[k].upd));
      check($sformatf("vec%0d err", k),   int'(d_err[vt[k].idx]),   int'(vt[k].err));
    end

    // Alternating bus with STABLE=1: a new value every pair, hence upd every cycle
    apply(1'b1, 1'b0, 4'h0);
    apply(1'b0, 1'b0, 4'h1);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, k[0] ? 1'b0 : 1'b1, 4'(k + 2));
      check("alt upd0", int'(d_upd[0]), 1);
    end

    // Randomized traffic: mostly a steady pattern with glitches, errors and resets
    pat_lo = 3; pat_hi = 9; phase = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        pat_lo = $urandom_range(0, 9);
        pat_hi = $urandom_range(0, 9);
      end
      phase = phase ^ 1;
      rc = ($urandom_range(0, 7) == 0) ? ~phase[0] : phase[0];
      rb = rc ? 4'(pat_hi) : 4'(pat_lo);
      if ($urandom_range(0, 9) == 0) rb = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 49) == 0);
      apply(rr, rc, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receive-side counterpart of the multiplexed two-digit `display` driver.
- Samples the time-multiplexed digit bus (`bcd` plus digit-select `cat`) and reassembles the displayed 8-bit value.
- Filters the value for stability, then presents it with update and error strobes.
- Used for board-level loopback self-test and for host readback of the displayed number.

Parameters:
- BASE, 16: digit radix. Legal range 2..16; 10 = decimal, 16 = hex.
- STABLE, 2: number of consecutive identical reassembled values required before `num` updates. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bcd  in  4  digit value currently driven on the display bus.
- cat  in  1  digit select: 0 = low (units) digit, 1 = high digit.
- num  out 8  last accepted value, hi*BASE+lo.
- valid out 1  high once any value has been accepted; sticky until reset.
- upd  out 1  one-cycle pulse when `num` takes a new value.
- err  out 1  one-cycle pulse on an out-of-range digit.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. The port list is fixed as above.
- Reset values: num=0, valid=0, upd=0, err=0. Internal state is cleared: hold state EMPTY, held digit 0, match count 0, candidate 0.
- `rst` asserted mid-pair discards the held digit, and the next sample starts fresh.
- Sampling: `bcd`/`cat` are sampled every rising edge. Inputs are synchronous to `clk`; no synchroniser is provided.
- Hold FSM has two states:
  - EMPTY: a legal digit is stored with its cat -> HELD.
  - HELD: the sample's cat differs from the held cat -> a pair completes; the current digit becomes the held digit, stay HELD. Pairs therefore overlap, and an alternating bus yields one pair per cycle.
  - HELD: the sample's cat equals the held cat -> the held digit is overwritten, no pair forms, match count is cleared to 0, stay HELD.
- Pair value: lo = digit sampled with cat=0, hi = digit sampled with cat=1, regardless of order. Value = hi*BASE+lo, computed in 8 bits. The maximum is (BASE-1)*(BASE+1) <= 255, so no overflow is possible.
- Stability filter:
  - If pair value equals the candidate, match count increments, saturating at STABLE.
  - Otherwise candidate <= pair value and match count <= 1.
  - When match count (after update) equals STABLE and the candidate differs from `num`, or `valid` is 0: num <= candidate, valid <= 1, and upd pulses for one cycle.
  - With STABLE=1, `num`/`upd` update on the same edge that samples the completing digit. Each extra STABLE step adds one cycle.
  - If the value equals the current `num`, there is no upd pulse.
- Range error: when a sampled bcd >= BASE, err pulses on that edge. FSM -> EMPTY, match count -> 0, and `num`/`valid` are unchanged. With BASE=16, err can never fire.
- Simultaneous events: `rst` dominates everything. An out-of-range digit dominates pair completion.
- `upd` and `err` are never high in the same cycle.

Test Plan:
- BASE=16, STABLE=1, reset then alternate cat=0/bcd=D, cat=1/bcd=2 -> on the second edge num=8'h2D, valid=1, upd pulses once; further identical cycles give no upd.
- BASE=10, STABLE=2, alternate lo=7, hi=4 for 4 cycles -> num=8'd47 (8'h2F) after the third sample edge (second matching pair), single upd pulse.
- BASE=16, STABLE=2, stable 8'h5A, then one glitch cycle cat=1/bcd=F, then back to 5A -> num stays 8'h5A, no upd.
- BASE=10, in steady state showing 47, drive cat=0/bcd=A -> err pulses 1 cycle, num stays 47, FSM EMPTY; the next two legal pairs re-accept with no upd (value unchanged).
- Drive cat=1 on two consecutive samples (3 then 6), then cat=0/bcd=1, BASE=16, STABLE=1 -> no pair on the repeat; result num=8'h61.
- Assert rst for 1 cycle after only a low-digit sample -> num=0, valid=0. The next hi-only sample does not complete a pair; a full pair is required before upd.
